// File: rtl/ff25519_pkg.sv
// Shared GF(2^255-19) definitions: field width, modulus, controller state encoding
// and the single-subtract canonicalisation used on incoming field elements.
package ff25519_pkg;

  localparam int W = 255;
  localparam logic [W-1:0] P_255 = {{(W-5){1'b1}}, 5'b01101};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ZCHK     = 3'd1,
    ST_INV_REQ  = 3'd2,
    ST_INV_WAIT = 3'd3,
    ST_MUL_REQ  = 3'd4,
    ST_MUL_WAIT = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  // Any v < 2^255 is below 2p, so one conditional subtract yields a canonical value.
  function automatic logic [W-1:0] reduce_once(input logic [W-1:0] v);
    logic [W-1:0] r_s;
    if (v >= P_255) begin
      r_s = v - P_255;
    end else begin
      r_s = v;
    end
    return r_s;
  endfunction

endpackage

// File: rtl/ff_to_affine_ctrl.sv
// Projective (X:Z) to affine u = X * Z^-1 mod p sequencer. Drives an external
// inverter and field multiplier over start/valid handshakes with a wait timeout.
module ff_to_affine_ctrl #(
  parameter int W         = 255,
  parameter int TO_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] z_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] u,
  output logic         err,
  output logic         inv_start,
  output logic [W-1:0] inv_a,
  input  logic [W-1:0] inv_res,
  input  logic         inv_valid,
  output logic         mul_start,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  input  logic [W-1:0] mul_res,
  input  logic         mul_valid
);
  import ff25519_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYCLES - 1);
  localparam bit               TO_EN    = (TO_CYCLES != 32'sd0);

  state_t           state_r;
  state_t           state_s;
  logic             timeout_s;
  logic             to_hit_s;
  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     xr_r;
  logic [W-1:0]     zr_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic             inv_start_r;
  logic             mul_start_r;
  logic [W-1:0]     u_r;
  logic [W-1:0]     inv_a_r;
  logic [W-1:0]     mul_a_r;
  logic [W-1:0]     mul_b_r;

  // cnt_r holds the number of completed cycles in the current WAIT state
  assign to_hit_s = TO_EN && (cnt_r == CNT_LAST);

  // Next-state decode; valids are only looked at in their own WAIT state
  always_comb begin
    state_s   = state_r;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_ZCHK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ZCHK: begin
        if (zr_r == {W{1'b0}}) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_INV_REQ;
        end
      end
      ST_INV_REQ: state_s = ST_INV_WAIT;
      ST_INV_WAIT: begin
        if (inv_valid) begin
          state_s = ST_MUL_REQ;
        end else if (to_hit_s) begin
          state_s   = ST_DONE;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_INV_WAIT;
        end
      end
      ST_MUL_REQ: state_s = ST_MUL_WAIT;
      ST_MUL_WAIT: begin
        if (mul_valid) begin
          state_s = ST_DONE;
        end else if (to_hit_s) begin
          state_s   = ST_DONE;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_MUL_WAIT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, registered strobes derived from the upcoming state, wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      inv_start_r <= 1'b0;
      mul_start_r <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s != ST_IDLE) && (state_s != ST_DONE);
      done_r      <= (state_s == ST_DONE);
      inv_start_r <= (state_s == ST_INV_REQ);
      mul_start_r <= (state_s == ST_MUL_REQ);
      if (((state_s == ST_INV_WAIT) || (state_s == ST_MUL_WAIT)) && (state_s == state_r)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  // Operand capture and result/error registers; u only changes on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr_r    <= {W{1'b0}};
      zr_r    <= {W{1'b0}};
      inv_a_r <= {W{1'b0}};
      mul_a_r <= {W{1'b0}};
      mul_b_r <= {W{1'b0}};
      u_r     <= {W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && start) begin
        xr_r <= reduce_once(x_in);
        zr_r <= reduce_once(z_in);
      end
      if (state_s == ST_INV_REQ) begin
        inv_a_r <= zr_r;
      end
      // mul_b doubles as the latched Z^-1
      if ((state_r == ST_INV_WAIT) && inv_valid) begin
        mul_a_r <= xr_r;
        mul_b_r <= inv_res;
      end
      if (state_s == ST_DONE) begin
        if ((state_r == ST_MUL_WAIT) && !timeout_s) begin
          u_r <= mul_res;
        end else begin
          u_r <= {W{1'b0}};
        end
        err_r <= timeout_s;
      end else begin
        err_r <= 1'b0;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign u         = u_r;
  assign inv_start = inv_start_r;
  assign inv_a     = inv_a_r;
  assign mul_start = mul_start_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;

endmodule
